// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: data word, ALU opcode and a bundled request.
package alu_share_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t op;
        word_t   a;
        word_t   b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N    = 2,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters with round-robin
// arbitration and a one-entry registered response buffer.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  alu_op_t            req_alu_op [NUM_REQ],
    input  word_t              req_in_a   [NUM_REQ],
    input  word_t              req_in_b   [NUM_REQ],
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output word_t              rsp_result,
    output logic               rsp_zero,
    output alu_op_t            alu_op,
    output word_t              in_a,
    output word_t              in_b,
    input  word_t              result,
    input  logic               zero
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               any_grant;
    logic               pop;
    logic               can_accept;
    logic               accept;
    alu_req_t           sel_req;

    logic               buf_full_q;
    logic [ID_W-1:0]    owner_q;
    logic [ID_W-1:0]    rr_ptr_q;
    word_t              result_q;
    logic               zero_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = ID_W'(i);
        end
    end

    assign any_grant  = |grant;
    // The buffer can reload in the same cycle its owner drains it.
    assign pop        = buf_full_q & rsp_ready[owner_q];
    assign can_accept = !buf_full_q | pop;
    assign accept     = any_grant & can_accept;
    assign req_ready  = grant & {NUM_REQ{can_accept}};

    always_comb begin
        sel_req = '0;
        if (any_grant) begin
            sel_req.op = req_alu_op[gnt_idx];
            sel_req.a  = req_in_a[gnt_idx];
            sel_req.b  = req_in_b[gnt_idx];
        end
    end

    assign alu_op = sel_req.op;
    assign in_a   = sel_req.a;
    assign in_b   = sel_req.b;

    always_comb begin
        rsp_valid = '0;
        if (buf_full_q) rsp_valid[owner_q] = 1'b1;
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else if (accept) begin
            buf_full_q <= 1'b1;
            owner_q    <= gnt_idx;
            rr_ptr_q   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            result_q   <= result;
            zero_q     <= zero;
        end else if (pop) begin
            buf_full_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a behavioural model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    alu_op_t       req_alu_op [N];
    word_t         req_in_a   [N];
    word_t         req_in_b   [N];
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    word_t         rsp_result;
    logic          rsp_zero;
    alu_op_t       alu_op;
    word_t         in_a;
    word_t         in_b;
    word_t         result;
    logic          zero;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int    m_ptr;
    bit    m_full;
    int    m_owner;
    word_t m_res;
    bit    m_zero;
    int    m_acc;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_alu_op (req_alu_op),
        .req_in_a   (req_in_a),
        .req_in_b   (req_in_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_op     (alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .result     (result),
        .zero       (zero)
    );

    function automatic word_t alu_ref(input alu_op_t op, input word_t a, input word_t b);
        case (op)
            AluAdd:  return a + b;
            AluSub:  return a - b;
            AluAnd:  return a & b;
            AluOr:   return a | b;
            AluXor:  return a ^ b;
            AluSll:  return a << b[4:0];
            AluSrl:  return a >> b[4:0];
            AluSra:  return word_t'($signed(a) >>> b[4:0]);
            AluSlt:  return {31'b0, $signed(a) < $signed(b)};
            AluSltu: return {31'b0, a < b};
            default: return '0;
        endcase
    endfunction

    // Shared ALU lives beside the arbiter
    always_comb begin
        result = alu_ref(alu_op, in_a, in_b);
        zero   = (result == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_full  = 0;
        m_owner = 0;
        m_res   = '0;
        m_zero  = 0;
        m_acc   = -1;
    endtask

    // Compare the current cycle against the model, then advance the model across the edge.
    task automatic model_step();
        int           g;
        bit           pop;
        bit           can;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        g   = exp_grant();
        pop = m_full && rsp_ready[m_owner];
        can = !m_full || pop;
        er  = '0;
        ev  = '0;
        if (g >= 0 && can) er[g] = 1'b1;
        if (m_full) ev[m_owner] = 1'b1;
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, ev);
        if (m_full) begin
            check("rsp_result", rsp_result, m_res);
            check("rsp_zero", rsp_zero, m_zero);
        end
        if (g < 0) begin
            check("idle_alu_op", alu_op, 0);
            check("idle_in_a", in_a, 0);
            check("idle_in_b", in_b, 0);
        end else if (can) begin
            check("alu_op", alu_op, req_alu_op[g]);
            check("in_a", in_a, req_in_a[g]);
            check("in_b", in_b, req_in_b[g]);
        end
        if (g >= 0 && can) begin
            m_full  = 1;
            m_owner = g;
            m_res   = alu_ref(req_alu_op[g], req_in_a[g], req_in_b[g]);
            m_zero  = (m_res == '0);
            m_ptr   = (g + 1) % N;
            m_acc   = g;
        end else begin
            m_acc = -1;
            if (pop) m_full = 0;
        end
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input alu_op_t op, input word_t a, input word_t b);
        req_valid[i]  = 1'b1;
        req_alu_op[i] = op;
        req_in_a[i]   = a;
        req_in_b[i]   = b;
    endtask

    // Random requesters: hold an unaccepted request, never issue while owning a response.
    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (m_acc == i) begin
                req_valid[i] = 1'b0;
            end else if (!req_valid[i] && !(m_full && m_owner == i)
                         && $urandom_range(0, 2) == 0) begin
                word_t a;
                a = $urandom;
                set_req(i, alu_op_t'($urandom_range(0, 9)), a,
                        ($urandom_range(0, 3) == 0) ? a : word_t'($urandom));
            end
            rsp_ready[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_alu_op[i] = AluAdd;
            req_in_a[i]   = '0;
            req_in_b[i]   = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_zero", rsp_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op
        set_req(0, AluAdd, 32'h0000_0005, 32'h0000_0003);
        rsp_ready = '1;
        #1;
        check("t1_req_ready", req_ready, 4'b0001);
        advance();
        req_valid = '0;
        #1;
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_result", rsp_result, 32'h0000_0008);
        check("t1_rsp_zero", rsp_zero, 0);
        advance();

        // Contention: pointer now at 1, so grants go 1,0,1,0...
        for (int k = 0; k < 8; k++) begin
            set_req(0, AluAdd, word_t'(k), 32'h10);
            set_req(1, AluXor, word_t'(k), 32'hff);
            #1;
            check("t2_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b0001);
            advance();
        end
        req_valid = '0;
        #1;
        advance();

        // Backpressure from requester 1
        set_req(1, AluSub, 32'h1234_5678, 32'h1234_5678);
        #1;
        check("t3_accept1", req_ready, 4'b0010);
        advance();
        req_valid[1] = 1'b0;
        set_req(0, AluOr, 32'hf0, 32'h0f);
        rsp_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_hold_valid", rsp_valid, 4'b0010);
            check("t3_hold_result", rsp_result, 0);
            check("t3_hold_zero", rsp_zero, 1);
            check("t3_blocked", req_ready, 4'b0000);
            advance();
        end
        rsp_ready[1] = 1'b1;
        #1;
        check("t3_pop_accept", req_ready, 4'b0001);
        advance();
        req_valid[0] = 1'b0;
        #1;
        check("t3_new_owner", rsp_valid, 4'b0001);
        check("t3_new_result", rsp_result, 32'hff);
        advance();

        // Wrap: move pointer to 3, then requests at 0 and 3
        set_req(2, AluAnd, 32'hf0f0, 32'hff00);
        #1;
        check("t4_grant2", req_ready, 4'b0100);
        advance();
        req_valid[2] = 1'b0;
        set_req(0, AluAdd, 32'd7, 32'd8);
        set_req(3, AluSll, 32'd1, 32'd4);
        #1;
        check("t4_grant3", req_ready, 4'b1000);
        advance();
        req_valid[3] = 1'b0;
        #1;
        check("t4_grant0", req_ready, 4'b0001);
        advance();
        req_valid = '0;
        #1;
        advance();

        // Reset mid-operation
        set_req(0, AluAdd, 32'd1, 32'd2);
        rsp_ready = '0;
        #1;
        check("t5_accept", req_ready, 4'b0001);
        advance();
        req_valid = '0;
        #1;
        check("t5_pending", rsp_valid, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("t5_async_clear", rsp_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_stay_clear", rsp_valid, 0);
            advance();
        end

        // Idle with a held response; pointer must not move
        set_req(1, AluSub, 32'd10, 32'd3);
        #1;
        advance();
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t6_alu_op", alu_op, 0);
            check("t6_held_result", rsp_result, 32'd7);
            check("t6_held_valid", rsp_valid, 4'b0010);
            advance();
        end
        rsp_ready = '1;
        set_req(0, AluAdd, 32'd1, 32'd1);
        set_req(3, AluAdd, 32'd2, 32'd2);
        #1;
        check("t6_ptr_kept", req_ready, 4'b1000);
        advance();
        req_valid = '0;
        #1;
        advance();

        // Randomized traffic
        m_acc = -1;
        for (int c = 0; c < 600; c++) begin
            gen();
            #1;
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
